// File: rtl/game_pkg.sv
// Shared types and defaults for the Whac-A-Mole round sequencer.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READY = 3'd1,
    PLAY  = 3'd2,
    PAUSE = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam int unsigned DEF_CLKS_PER_MS         = 50000;
  localparam int unsigned DEF_GAME_LENGTH_SECONDS = 20;
  localparam int unsigned DEF_READY_SECONDS       = 3;
  localparam int unsigned MS_PER_SEC              = 1000;
  localparam int unsigned MS_CNT_W                = 10;

  // Width of a millisecond count spanning a whole round.
  function automatic int unsigned ms_width(input int unsigned seconds);
    return $clog2(MS_PER_SEC * seconds);
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// One-cycle tick every CLKS_PER_MS clocks; clear holds the prescaler at zero.
module ms_tick_gen
  import game_pkg::*;
#(
  parameter int unsigned CLKS_PER_MS = DEF_CLKS_PER_MS
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLKS_PER_MS - 1);

  logic [PW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/game_controller.sv
// Round sequencer: IDLE -> READY count-in -> PLAY <-> PAUSE -> OVER.
module game_controller
  import game_pkg::*;
#(
  parameter int unsigned GAME_LENGTH_SECONDS = DEF_GAME_LENGTH_SECONDS,
  parameter int unsigned CLKS_PER_MS         = DEF_CLKS_PER_MS,
  parameter int unsigned READY_SECONDS       = DEF_READY_SECONDS
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start,
  input  logic                                     pause,
  input  logic [ms_width(GAME_LENGTH_SECONDS)-1:0] time_ms,
  output logic                                     timer_rst,
  output logic                                     timer_enable,
  output logic [2:0]                               state,
  output logic [$clog2(READY_SECONDS+1)-1:0]       ready_digit,
  output logic                                     game_active,
  output logic                                     game_over,
  output logic                                     score_clear
);

  localparam int unsigned RDW = $clog2(READY_SECONDS + 1);

  state_t              state_q;
  state_t              state_d;
  logic [MS_CNT_W-1:0] ms_cnt;
  logic                ms_tick;
  logic                ms_wrap;
  logic                entering_ready;

  ms_tick_gen #(
    .CLKS_PER_MS(CLKS_PER_MS)
  ) u_ms_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(state_q != READY),
    .tick (ms_tick)
  );

  assign ms_wrap        = ms_tick && (ms_cnt == MS_CNT_W'(MS_PER_SEC - 1));
  assign entering_ready = (state_d == READY) && (state_q != READY);
  assign state          = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = READY;
      READY:   if (ms_wrap && ready_digit == RDW'(1)) state_d = PLAY;
      // Timer expiry outranks a pause arriving in the same cycle.
      PLAY:    if (time_ms == '0) state_d = OVER;
               else if (pause) state_d = PAUSE;
      PAUSE:   if (pause) state_d = PLAY;
      OVER:    if (start) state_d = READY;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ms_cnt       <= '0;
      ready_digit  <= '0;
      score_clear  <= 1'b0;
      timer_rst    <= 1'b1;
      timer_enable <= 1'b0;
      game_active  <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      state_q <= state_d;

      if (state_q != READY) begin
        ms_cnt <= '0;
      end else if (ms_tick) begin
        ms_cnt <= ms_wrap ? '0 : ms_cnt + 1'b1;
      end

      if (entering_ready) begin
        ready_digit <= RDW'(READY_SECONDS);
      end else if (state_q != READY) begin
        ready_digit <= '0;
      end else if (ms_wrap) begin
        ready_digit <= ready_digit - 1'b1;
      end

      score_clear  <= entering_ready;
      timer_rst    <= (state_d == IDLE) || (state_d == READY);
      timer_enable <= (state_d == PLAY);
      game_active  <= (state_d == PLAY);
      game_over    <= (state_d == OVER);
    end
  end

endmodule

// File: tb/tb_game_controller.sv
// Random start/pause/reset traffic against a cycle-count reference model with a behavioural timer.
module tb_game_controller;

  localparam int unsigned CLKS   = 2;
  localparam int unsigned LEN_S  = 1;
  localparam int unsigned RDY_S  = 2;
  localparam int unsigned TW     = $clog2(1000 * LEN_S);
  localparam int unsigned DW     = $clog2(RDY_S + 1);
  localparam int          P      = 1000 * CLKS;
  localparam int          R      = RDY_S * P;
  localparam int          TFULL  = 1000 * LEN_S;
  localparam int          N_CYC  = 60000;

  logic          clk = 1'b0;
  logic          rst, start, pause;
  logic [TW-1:0] time_ms;
  logic          timer_rst, timer_enable, game_active, game_over, score_clear;
  logic [2:0]    state;
  logic [DW-1:0] ready_digit;

  int checks   = 0;
  int failures = 0;

  game_controller #(
    .GAME_LENGTH_SECONDS(LEN_S),
    .CLKS_PER_MS        (CLKS),
    .READY_SECONDS      (RDY_S)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pause       (pause),
    .time_ms     (time_ms),
    .timer_rst   (timer_rst),
    .timer_enable(timer_enable),
    .state       (state),
    .ready_digit (ready_digit),
    .game_active (game_active),
    .game_over   (game_over),
    .score_clear (score_clear)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: state number, cycles left in the count-in, and the timer's ms count/prescale.
  int mst, rem, tm, tpre, old;
  bit r_rst, r_start, r_pause;

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0; time_ms = TW'(TFULL);
    repeat (10) @(negedge clk);
    check_eq("rst_state", 32'(state), 0);
    check_eq("rst_timer_rst", 32'(timer_rst), 1);
    check_eq("rst_timer_enable", 32'(timer_enable), 0);
    check_eq("rst_game_active", 32'(game_active), 0);
    check_eq("rst_game_over", 32'(game_over), 0);
    check_eq("rst_score_clear", 32'(score_clear), 0);
    check_eq("rst_ready_digit", 32'(ready_digit), 0);

    mst = 0; rem = 0; tm = TFULL; tpre = 0;
    rst = 1'b0;
    @(negedge clk);

    for (int cyc = 0; cyc < N_CYC && failures < 50; cyc++) begin
      check_eq("state", 32'(state), 32'(mst));
      check_eq("ready_digit", 32'(ready_digit), (mst == 1) ? 32'((rem + P - 1) / P) : 0);
      check_eq("score_clear", 32'(score_clear), 32'(mst == 1 && rem == R));
      check_eq("timer_rst", 32'(timer_rst), 32'(mst <= 1));
      check_eq("timer_enable", 32'(timer_enable), 32'(mst == 2));
      check_eq("game_active", 32'(game_active), 32'(mst == 2));
      check_eq("game_over", 32'(game_over), 32'(mst == 4));

      r_rst   = ($urandom_range(0, 7999) == 0);
      r_start = ($urandom_range(0, 399) == 0);
      r_pause = ($urandom_range(0, 249) == 0);
      if (mst == 2 && tm == 0 && $urandom_range(0, 1) == 1) r_pause = 1'b1;
      if (r_start && $urandom_range(0, 1) == 1) r_pause = 1'b1;
      rst = r_rst; start = r_start; pause = r_pause; time_ms = TW'(tm);

      old = mst;
      if (r_rst) begin
        mst = 0; rem = 0;
      end else begin
        case (mst)
          0, 4: if (r_start) begin mst = 1; rem = R; end
          1: begin
            rem--;
            if (rem == 0) mst = 2;
          end
          2: if (tm == 0) mst = 4; else if (r_pause) mst = 3;
          3: if (r_pause) mst = 2;
          default: mst = 0;
        endcase
      end

      // The timer follows the controller outputs in force during this cycle.
      if (old <= 1) begin
        tm = TFULL; tpre = 0;
      end else if (old == 2) begin
        if (tpre == CLKS - 1) begin
          tpre = 0;
          if (tm > 0) tm--;
        end else begin
          tpre++;
        end
      end

      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
